// File: rtl/ifetch_unit_pkg.sv
// Shared encodings for the instruction-fetch stage: PC-select codes, opcodes
// and fetch FSM states.
package ifetch_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] PC_SRC_NEXTINS = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH  = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_JR  = 6'h06;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/acknowledge port.
interface ifetch_unit_if;
  import ifetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/ifetch_unit_next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, J-type
// region jump or register-indirect jump, plus an alignment flag.
module ifetch_unit_next_pc_calc
  import ifetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] rs_data,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] br_off;

  assign pc_plus4 = pc + XLEN'(4);
  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (pc_src)
      PC_SRC_BRANCH: next_pc = pc_plus4 + br_off;
      PC_SRC_JUMP: begin
        if (instr[31:26] == OP_JR) next_pc = rs_data;
        else                       next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
      end
      default: next_pc = pc_plus4;
    endcase
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch/PC-sequencing stage: fetches over a req/ack port, holds the
// instruction while it executes, and commits the next PC.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0]  RESET_PC      = 32'h0000_0000,
  parameter int unsigned  FETCH_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  ifetch_unit_if.master     imem,
  input  logic [1:0]        PcSrc,
  input  logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   instr,
  output logic              instr_valid,
  output logic [5:0]        Op,
  output logic [5:0]        Func,
  output logic [4:0]        Rs,
  output logic [4:0]        Rt,
  output logic [4:0]        Rd,
  output logic [4:0]        Sa,
  output logic [15:0]       Imm16,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              fetch_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            imem_req_q, imem_req_d;
  logic            fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  ifetch_unit_next_pc_calc u_next_pc_calc (
    .pc         (pc_q),
    .instr      (instr_q),
    .pc_src     (PcSrc),
    .rs_data    (rs_data),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    fetch_err_d   = fetch_err_q;
    cnt_d         = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
        cnt_d      = '0;
      end
      S_FETCH: begin
        if (imem_req_q && imem.imem_ack) begin
          instr_d       = imem.imem_rdata;
          instr_valid_d = 1'b1;
          imem_req_d    = 1'b0;
          state_d       = S_EXEC;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(FETCH_TIMEOUT)) begin
            fetch_err_d = 1'b1;
            imem_req_d  = 1'b0;
            state_d     = S_HALT;
          end
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d          = next_pc;
          cnt_d         = '0;
          instr_valid_d = 1'b0;
          // A misaligned target is committed for visibility but never fetched.
          if (misaligned) begin
            fetch_err_d = 1'b1;
            state_d     = S_HALT;
          end else begin
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_HALT: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      fetch_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      fetch_err_q   <= fetch_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = instr_valid_q;
  assign pc             = pc_q;
  assign fetch_err      = fetch_err_q;
  assign Op             = instr_q[31:26];
  assign Rs             = instr_q[25:21];
  assign Rt             = instr_q[20:16];
  assign Rd             = instr_q[15:11];
  assign Sa             = instr_q[10:6];
  assign Func           = instr_q[5:0];
  assign Imm16          = instr_q[15:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed control-flow cases, random
// instruction streams against a transaction-level PC model, timeout and reset.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam int unsigned TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [1:0]  PcSrc;
  logic [31:0] rs_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  Op, Func;
  logic [4:0]  Rs, Rt, Rd, Sa;
  logic [15:0] Imm16;
  logic [31:0] pc, pc_plus4;
  logic        fetch_err;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] model_pc;

  ifetch_unit_if imem ();

  ifetch_unit #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem(imem),
    .PcSrc(PcSrc), .rs_data(rs_data), .instr(instr), .instr_valid(instr_valid),
    .Op(Op), .Func(Func), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Sa(Sa), .Imm16(Imm16),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule computed with plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                           input logic [1:0] src, input logic [31:0] rs);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(word[15:0])) * 4;
    if (src == 2'b01) return seq + 32'(off);
    if (src == 2'b10) begin
      if ((word >> 26) == 32'(OP_JR)) return rs;
      return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    end
    return seq;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    imem.imem_ack = 1'b0;
    imem.imem_rdata = $urandom;
    tick();
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req", 32'(imem.imem_req), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;
    model_pc = 32'h0;
    tick();
    check("idle_to_fetch_req", 32'(imem.imem_req), 32'd1);
    check("idle_to_fetch_addr", imem.imem_addr, 32'h0);
  endtask

  task automatic wait_req();
    int k = 0;
    while (imem.imem_req !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    check("req_rise", 32'(imem.imem_req), 32'd1);
  endtask

  task automatic do_instr(input logic [31:0] word, input int delay, input int nstall,
                          input logic [1:0] src, input logic [31:0] rs);
    logic [31:0] nxt;
    wait_req();
    check("fetch_addr", imem.imem_addr, model_pc);
    check("fetch_pc", pc, model_pc);
    for (int i = 0; i < delay; i++) begin
      imem.imem_ack = 1'b0;
      tick();
      check("req_hold", 32'(imem.imem_req), 32'd1);
    end
    imem.imem_ack = 1'b1;
    imem.imem_rdata = word;
    tick();
    imem.imem_ack = 1'b0;
    imem.imem_rdata = $urandom;
    check("exec_valid", 32'(instr_valid), 32'd1);
    check("exec_req", 32'(imem.imem_req), 32'd0);
    check("instr", instr, word);
    check("Op", 32'(Op), word >> 26);
    check("Rs", 32'(Rs), (word >> 21) & 32'h1F);
    check("Rt", 32'(Rt), (word >> 16) & 32'h1F);
    check("Rd", 32'(Rd), (word >> 11) & 32'h1F);
    check("Sa", 32'(Sa), (word >> 6) & 32'h1F);
    check("Func", 32'(Func), word & 32'h3F);
    check("Imm16", 32'(Imm16), word & 32'hFFFF);
    check("exec_pc", pc, model_pc);
    check("pc_plus4", pc_plus4, model_pc + 32'd4);
    PcSrc = src;
    rs_data = rs;
    stall = (nstall > 0);
    for (int i = 0; i < nstall; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_pc", pc, model_pc);
      check("stall_instr", instr, word);
      check("stall_req", 32'(imem.imem_req), 32'd0);
    end
    stall = 1'b0;
    tick();
    nxt = ref_next(model_pc, word, src, rs);
    PcSrc = 2'($urandom);
    rs_data = $urandom;
    check("commit_pc", pc, nxt);
    check("commit_valid", 32'(instr_valid), 32'd0);
    if (nxt[1:0] != 2'b00) begin
      check("misalign_err", 32'(fetch_err), 32'd1);
      check("misalign_req", 32'(imem.imem_req), 32'd0);
    end else begin
      check("next_req", 32'(imem.imem_req), 32'd1);
      check("next_err", 32'(fetch_err), 32'd0);
    end
    model_pc = nxt;
  endtask

  initial begin
    int k;
    PcSrc = 2'b00;
    rs_data = 32'h0;
    do_reset();

    // Sequential fetch at 0, 4, 8.
    for (int i = 0; i < 3; i++) do_instr(32'h2008_0005, 0, 0, PC_SRC_NEXTINS, 32'h0);

    // Region jump to 0x100, backward and forward branches.
    do_instr(32'h0800_0040, 1, 0, PC_SRC_JUMP, 32'h0);
    do_instr(32'h1000_FFFE, 0, 0, PC_SRC_BRANCH, 32'h0);
    check("branch_back", model_pc, 32'h0000_00FC);
    do_instr(32'h0800_0040, 2, 0, PC_SRC_JUMP, 32'h0);
    do_instr(32'h1000_0003, 0, 0, PC_SRC_BRANCH, 32'h0);
    check("branch_fwd", model_pc, 32'h0000_0110);

    // Register jump into high region, J keeps the region bits, JR back down.
    do_instr(32'h1BE0_0000, 0, 0, PC_SRC_JUMP, 32'hA000_0000);
    do_instr(32'h0800_0040, 0, 0, PC_SRC_JUMP, 32'h0);
    check("j_region", model_pc, 32'hA000_0100);
    do_instr(32'h1BE0_0000, 0, 0, PC_SRC_JUMP, 32'h0000_2000);

    // Three stall cycles, then PC wrap through the top of memory.
    do_instr(32'h2008_0005, 0, 3, PC_SRC_NEXTINS, 32'h0);
    do_instr(32'h1BE0_0000, 0, 0, PC_SRC_JUMP, 32'hFFFF_FFFC);
    do_instr(32'h0000_0000, 0, 0, 2'b11, 32'h0);
    check("pc_wrap", model_pc, 32'h0);

    for (int i = 0; i < 40; i++)
      do_instr($urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
               2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FFFC);

    // Misaligned JR target halts with no further requests.
    do_instr(32'h1BE0_0000, 0, 0, PC_SRC_JUMP, 32'h0000_2002);
    for (int i = 0; i < 6; i++) begin
      imem.imem_ack = 1'($urandom);
      tick();
      check("halt_req", 32'(imem.imem_req), 32'd0);
      check("halt_pc", pc, 32'h0000_2002);
      check("halt_instr", instr, 32'h1BE0_0000);
      check("halt_err", 32'(fetch_err), 32'd1);
    end

    // Withheld ack: error exactly TMO cycles after the request rises.
    do_reset();
    k = 0;
    for (int i = 1; i <= int'(TMO) + 4; i++) begin
      tick();
      k = i;
      if (fetch_err === 1'b1) break;
      check("tmo_req_high", 32'(imem.imem_req), 32'd1);
    end
    check("tmo_cycles", 32'(k), 32'(TMO));
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem.imem_ack = 1'b0;
    check("late_ack_valid", 32'(instr_valid), 32'd0);
    check("late_ack_instr", instr, 32'h0);
    check("late_ack_req", 32'(imem.imem_req), 32'd0);
    check("late_ack_err", 32'(fetch_err), 32'd1);

    // Reset mid-fetch discards a coincident ack.
    do_reset();
    do_instr(32'h2008_0005, 0, 0, PC_SRC_NEXTINS, 32'h0);
    do_instr(32'h2008_0005, 0, 0, PC_SRC_NEXTINS, 32'h0);
    tick();
    check("midfetch_addr", imem.imem_addr, 32'h8);
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'h1234_5678;
    rst_n = 1'b0;
    tick();
    imem.imem_ack = 1'b0;
    check("midrst_req", 32'(imem.imem_req), 32'd0);
    check("midrst_pc", pc, 32'h0);
    check("midrst_instr", instr, 32'h0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_refetch", 32'(imem.imem_req), 32'd1);
    check("midrst_addr", imem.imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
